// File: rtl/io_handler_mc_if.sv
// CPU-side IO bus plus external pins for io_handler_mc.
// The master side is the CPU/pin driver, the slave side is the handler.
interface io_handler_mc_if #(
    parameter int unsigned DATA_W = 8
);
    logic [2:0]        io_addr;
    logic              io_write;
    logic              io_read;
    logic [DATA_W-1:0] io_wdata;
    logic [DATA_W-1:0] io_rdata;
    logic              io_irq;
    logic [DATA_W-1:0] io_in;
    logic [DATA_W-1:0] io_out;

    modport master (
        output io_addr, io_write, io_read, io_wdata, io_in,
        input  io_rdata, io_irq, io_out
    );

    modport slave (
        input  io_addr, io_write, io_read, io_wdata, io_in,
        output io_rdata, io_irq, io_out
    );
endinterface

// File: rtl/io_handler_mc.sv
// Register-mapped IO port with change-capture input FIFO, sticky overflow and level irq.
// Optional IO_HANDLER_OUT_SETCLR_EN adds OUT_SET (addr 5) and OUT_CLR (addr 6).
module io_handler_mc #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          reset,
    io_handler_mc_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] in_q;
    logic [DATA_W-1:0] out_q, out_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              irq_q, irq_d;

    logic              empty, full, pop, change, push, ovf_set;
    logic [DATA_W-1:0] status;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        pop     = bus.io_read && (bus.io_addr == 3'd1) && !empty;
        change  = ctrl_q[0] && (bus.io_in != in_q);
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
        push    = change && (!full || pop);
        ovf_set = change && full && !pop;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        status      = '0;
        status[0]   = empty;
        status[1]   = full;
        status[2]   = ovf_q;
        status[7:3] = 5'(count_q);

        out_d  = out_q;
        ctrl_d = ctrl_q;
        ovf_d  = ovf_q;
        if (bus.io_write) begin
            case (bus.io_addr)
                3'd0: out_d = bus.io_wdata;
                3'd2: ctrl_d = bus.io_wdata[2:0];
                3'd3: if (bus.io_wdata[2]) ovf_d = 1'b0;
`ifdef IO_HANDLER_OUT_SETCLR_EN
                3'd5: out_d = out_q | bus.io_wdata;
                3'd6: out_d = out_q & ~bus.io_wdata;
`endif
                default: ;
            endcase
        end
        if (ovf_set) ovf_d = 1'b1;

        irq_d = (ctrl_d[1] && (count_d != '0)) || (ctrl_d[2] && ovf_d);

        rdata_d = rdata_q;
        if (bus.io_read) begin
            case (bus.io_addr)
                3'd0:    rdata_d = out_q;
                3'd1:    rdata_d = empty ? '0 : mem[rd_ptr_q];
                3'd2:    rdata_d = DATA_W'(ctrl_q);
                3'd3:    rdata_d = status;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            in_q     <= '0;
            out_q    <= '0;
            ctrl_q   <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr_q] <= bus.io_in;
                wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            in_q    <= bus.io_in;
            out_q   <= out_d;
            ctrl_q  <= ctrl_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.io_rdata = rdata_q;
    assign bus.io_irq   = irq_q;
    assign bus.io_out   = out_q;
endmodule

// File: tb/tb_io_handler_mc.sv
// Directed bench for io_handler_mc (DATA_W=8, FIFO_DEPTH=4).
module tb_io_handler_mc;
    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [7:0] rd;

    always #5 clk = ~clk;

    io_handler_mc_if #(.DATA_W(8)) bus ();

    io_handler_mc #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.io_addr  = addr;
        bus.io_wdata = data;
        bus.io_write = 1'b1;
        @(negedge clk);
        bus.io_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [7:0] data);
        @(negedge clk);
        bus.io_addr = addr;
        bus.io_read = 1'b1;
        @(negedge clk);
        bus.io_read = 1'b0;
        data = bus.io_rdata;
    endtask

    initial begin
        logic [7:0] exp_vals [4];
        reset        = 1'b1;
        bus.io_addr  = '0;
        bus.io_write = 1'b0;
        bus.io_read  = 1'b0;
        bus.io_wdata = '0;
        bus.io_in    = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_out", bus.io_out, 8'h00);
        check_eq("rst_irq", bus.io_irq, 1'b0);
        check_eq("rst_rdata", bus.io_rdata, 8'h00);
        reset = 1'b0;

        bus_read(3'd0, rd); check_eq("rst_r0", rd, 8'h00);
        bus_read(3'd1, rd); check_eq("rst_r1", rd, 8'h00);
        bus_read(3'd2, rd); check_eq("rst_r2", rd, 8'h00);
        bus_read(3'd3, rd); check_eq("rst_status", rd, 8'h01);

        bus_write(3'd0, 8'hA5);
        check_eq("out_a5", bus.io_out, 8'hA5);
        bus_read(3'd0, rd); check_eq("r0_a5", rd, 8'hA5);

        // Read and write of DATA_OUT in one cycle: read sees the old value.
        @(negedge clk);
        bus.io_addr  = 3'd0;
        bus.io_wdata = 8'h5A;
        bus.io_write = 1'b1;
        bus.io_read  = 1'b1;
        @(negedge clk);
        bus.io_write = 1'b0;
        bus.io_read  = 1'b0;
        check_eq("rw_rdata", bus.io_rdata, 8'hA5);
        check_eq("rw_out", bus.io_out, 8'h5A);

        bus_write(3'd2, 8'hFB);
        bus_read(3'd2, rd); check_eq("ctrl_mask", rd, 8'h03);
        check_eq("irq_ne_empty", bus.io_irq, 1'b0);

        @(negedge clk) bus.io_in = 8'h11;
        @(negedge clk) bus.io_in = 8'h22;
        @(negedge clk);
        check_eq("irq_ne", bus.io_irq, 1'b1);
        bus_read(3'd3, rd); check_eq("status_cnt2", rd, 8'h10);
        bus_read(3'd1, rd); check_eq("pop_11", rd, 8'h11);
        bus_read(3'd1, rd); check_eq("pop_22", rd, 8'h22);
        check_eq("irq_drop", bus.io_irq, 1'b0);
        bus_read(3'd3, rd); check_eq("status_empty", rd, 8'h01);
        bus_read(3'd1, rd); check_eq("pop_empty", rd, 8'h00);

        bus_write(3'd2, 8'h05);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus.io_in = 8'h30 + 8'(i);
        end
        @(negedge clk);
        check_eq("irq_full_no_ovf", bus.io_irq, 1'b0);
        bus.io_in = 8'h35;
        @(negedge clk);
        check_eq("irq_ovf", bus.io_irq, 1'b1);
        bus_read(3'd3, rd); check_eq("status_ovf", rd, 8'h26);
        bus_write(3'd3, 8'h04);
        check_eq("irq_ovf_clr", bus.io_irq, 1'b0);
        bus_read(3'd3, rd); check_eq("status_w1c", rd, 8'h22);

        // Pop from a full FIFO while a new value is captured.
        @(negedge clk);
        bus.io_addr = 3'd1;
        bus.io_read = 1'b1;
        bus.io_in   = 8'h36;
        @(negedge clk);
        bus.io_read = 1'b0;
        check_eq("full_pushpop", bus.io_rdata, 8'h31);
        bus_read(3'd3, rd); check_eq("status_pushpop", rd, 8'h22);
        check_eq("irq_pushpop", bus.io_irq, 1'b0);
        exp_vals[0] = 8'h32;
        exp_vals[1] = 8'h33;
        exp_vals[2] = 8'h34;
        exp_vals[3] = 8'h36;
        for (int i = 0; i < 4; i++) begin
            bus_read(3'd1, rd);
            check_eq($sformatf("drain%0d", i), rd, exp_vals[i]);
        end
        bus_read(3'd3, rd); check_eq("status_drained", rd, 8'h01);

        bus_write(3'd7, 8'hEE);
        bus_write(3'd4, 8'h11);
        check_eq("rsvd_wr", bus.io_out, 8'h5A);
        bus_read(3'd7, rd); check_eq("rsvd_r7", rd, 8'h00);
        bus_read(3'd4, rd); check_eq("rsvd_r4", rd, 8'h00);

        bus_write(3'd0, 8'h0F);
        bus_write(3'd5, 8'hF0);
`ifdef IO_HANDLER_OUT_SETCLR_EN
        check_eq("out_set", bus.io_out, 8'hFF);
`else
        check_eq("out_set", bus.io_out, 8'h0F);
`endif
        bus_read(3'd5, rd); check_eq("r5", rd, 8'h00);
        bus_write(3'd6, 8'h3C);
`ifdef IO_HANDLER_OUT_SETCLR_EN
        check_eq("out_clr", bus.io_out, 8'hC3);
`else
        check_eq("out_clr", bus.io_out, 8'h0F);
`endif
        bus_read(3'd6, rd); check_eq("r6", rd, 8'h00);

        // Reset while capturing discards FIFO contents.
        bus_write(3'd2, 8'h01);
        @(negedge clk) bus.io_in = 8'h40;
        @(negedge clk) bus.io_in = 8'h41;
        @(negedge clk);
        reset     = 1'b1;
        bus.io_in = 8'h42;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst2_out", bus.io_out, 8'h00);
        bus_read(3'd3, rd); check_eq("rst2_status", rd, 8'h01);
        bus_read(3'd2, rd); check_eq("rst2_ctrl", rd, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/io_handler_mc.md
# io_handler_mc

Parametrised successor to the single-register IO handler: a register-mapped IO port of configurable data width with a change-capture input FIFO, sticky overflow, and maskable level interrupt. Sits between the CPU's IO bus (addr/read/write strobes) and the external pins, alongside the existing IO handler in the peripheral region.

## Interface
- DATA_W, 8, width of io_in/io_out/io_wdata/io_rdata; legal range 8..32.
- FIFO_DEPTH, 4, input capture FIFO entries; power of two, 2..16.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- io_addr  input  3  register select.
- io_write  input  1  write strobe, one cycle per access.
- io_read  input  1  read strobe, one cycle per access.
- io_wdata  input  DATA_W  write data.
- io_rdata  output  DATA_W  registered read data.
- io_irq  output  1  registered level interrupt.
- io_in  input  DATA_W  external input pins, synchronous to clk.
- io_out  output  DATA_W  external output pins.

## Operation
- Register map:
  - 0 DATA_OUT (RW): drives io_out directly.
  - 1 DATA_IN (RO): read returns FIFO head and pops it; empty FIFO returns 0, no pop.
  - 2 CONTROL (RW): bit0 CAP_EN, bit1 IRQ_NE_EN (irq on not-empty), bit2 IRQ_OVF_EN; other bits read 0.
  - 3 STATUS: bit0 EMPTY, bit1 FULL, bit2 OVF (sticky, write 1 to clear), bits[7:3] COUNT (entries, zero-extended). Writes to bits other than bit2 ignored.
  - 4..7: reads return 0, writes ignored (unless the configuration macro is defined).
- Capture: io_in_q samples io_in every cycle regardless of CAP_EN. When CAP_EN=1 and io_in != io_in_q, the current io_in value is pushed.
- Push when full and no pop that cycle: value dropped, OVF set.
- Push and pop in same cycle: both occur; count unchanged; no OVF even when full.
- Pointers wrap modulo FIFO_DEPTH; COUNT ranges 0..FIFO_DEPTH.
- io_read and io_write in the same cycle: both performed; read returns pre-write value.
- OVF set and W1C in the same cycle: set wins.
- io_irq = (IRQ_NE_EN & !EMPTY) | (IRQ_OVF_EN & OVF), evaluated on next-state values, registered.

## Timing
- Reset values: io_out=0, io_rdata=0, io_irq=0, CONTROL=0, OVF=0, FIFO empty, io_in_q=0.
- Reset is synchronous and overrides any access in that cycle; FIFO contents are discarded on reset at any time, including mid-capture.
- io_rdata valid the cycle after io_read; holds its value until the next read.
- DATA_IN pop takes effect at the same edge that registers io_rdata.
- io_out updates one cycle after the DATA_OUT write strobe.
- Capture latency: an io_in change sampled at edge N is pushed at edge N and is visible in COUNT at edge N+1 (read issued at N+1 returns it at N+2).
- io_irq asserts on the edge where the causing state changes, i.e. in the same cycle as the state change becomes visible.

## Configuration
- IO_HANDLER_OUT_SETCLR_EN defined: address 5 OUT_SET (write-only) ORs io_wdata into DATA_OUT; address 6 OUT_CLR (write-only) clears DATA_OUT bits set in io_wdata; both read 0. A simultaneous set and clear cannot occur (single address per cycle).
- Not defined: addresses 5 and 6 behave as reserved (reads 0, writes ignored).

## Test plan
- Reset, then read addresses 0..3 -> 0x00, 0x00, 0x00, STATUS=0x01 (EMPTY); io_irq=0, io_out=0.
- Write DATA_OUT=0xA5 -> io_out=0xA5 one cycle later; read addr 0 -> 0xA5.
- CONTROL=0x03; drive io_in 0x00->0x11->0x22 on consecutive cycles -> COUNT=2, io_irq=1; two DATA_IN reads return 0x11 then 0x22; EMPTY=1; io_irq drops.
- FIFO_DEPTH=4, CONTROL=0x05; five io_in changes with no reads -> FULL=1, OVF=1, io_irq=1, first four values retained; write STATUS=0x04 -> OVF=0, io_irq=0.
- With FIFO full, issue a DATA_IN read in the same cycle as an io_in change -> COUNT stays 4, OVF stays 0, oldest entry returned.
- Macro defined: DATA_OUT=0x0F, write OUT_SET=0xF0 -> io_out=0xFF; write OUT_CLR=0x3C -> io_out=0xC3. Macro undefined: the same writes leave io_out=0x0F.
